// File: rtl/operand_sequencer_pkg.sv
// Shared calculator definitions used by the operand sequencer and the ALU.
// Holds the sequencer stage enum, the op-code encodings, the RGB error codes
// and the decode from a stage to its one-hot stage indicator.
package operand_sequencer_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_CALC = 3'd3,
    S_SHOW = 3'd4
  } state_e;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  localparam logic [2:0] ERR_NONE     = 3'b000;
  localparam logic [2:0] ERR_OVERFLOW = 3'b001;
  localparam logic [2:0] ERR_CARRY    = 3'b010;
  localparam logic [2:0] ERR_BAD_OP   = 3'b100;

  // Both calculation stages light all three LEDs so the user sees "busy/result".
  function automatic logic [2:0] stage_leds(input state_e s);
    case (s)
      S_A:     stage_leds = 3'b001;
      S_B:     stage_leds = 3'b010;
      S_OP:    stage_leds = 3'b100;
      default: stage_leds = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/operand_sequencer_if.sv
// Bus between the operand sequencer, its switch/button front end and the ALU.
// Signals:
//   data_in    switch value (synchronized)       enter/undo  debounced button levels
//   result_in  ALU combinational result          error_in    ALU error code
//   A/B/OP     registered operands and op-code   disp_value  7-segment value
//   state_leds one-hot stage indicator           error_out   latched error code
//   done       latched result on display
// Modports: master drives the inputs (front end + ALU), slave is the sequencer.
interface operand_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data_in;
  logic             enter;
  logic             undo;
  logic [WIDTH-1:0] result_in;
  logic [2:0]       error_in;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] OP;
  logic [WIDTH-1:0] disp_value;
  logic [2:0]       state_leds;
  logic [2:0]       error_out;
  logic             done;

  modport master (
    output data_in, enter, undo, result_in, error_in,
    input  A, B, OP, disp_value, state_leds, error_out, done
  );

  modport slave (
    input  data_in, enter, undo, result_in, error_in,
    output A, B, OP, disp_value, state_leds, error_out, done
  );
endinterface

// File: rtl/operand_sequencer_button_edge.sv
// Rising-edge detector for one debounced button level.
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   btn_i       debounced button level
//   press_o     registered one-cycle pulse per rising edge of btn_i
// A level that is already high when reset releases is not a press: the arm
// flag holds off detection for the first cycle while the level copy fills.
module button_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);
  logic armed_q;
  logic btn_q;
  logic press_q;
  logic press_d;

  assign press_d = armed_q & btn_i & ~btn_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q <= 1'b0;
      btn_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      btn_q   <= btn_i;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;
endmodule

// File: rtl/operand_sequencer.sv
// Calculator operand sequencer: walks the user through entering A, B and an
// op-code, hands them to the ALU, then latches and shows the result.
// Ports:
//   clk    system clock (rising edge)
//   reset  asynchronous active-high reset
//   bus    operand_sequencer_if slave modport (buttons, switches, ALU link,
//          display and LED outputs)
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  operand_sequencer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, op_q, res_q;
  logic [2:0]       err_q;

  logic enter_press;
  logic undo_press;

  logic load_a, load_b, load_op, load_res, clear_all, clear_err;

  button_edge u_enter_edge (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (bus.enter),
    .press_o (enter_press)
  );

  button_edge u_undo_edge (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (bus.undo),
    .press_o (undo_press)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Undo takes priority over enter in every stage; in S_A the collision is
  // simply dropped. S_CALC ignores both buttons and always advances.
  always_comb begin
    state_d   = state_q;
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_op   = 1'b0;
    load_res  = 1'b0;
    clear_all = 1'b0;
    clear_err = 1'b0;

    case (state_q)
      S_A: begin
        if (enter_press && !undo_press) begin
          load_a  = 1'b1;
          state_d = S_B;
        end
      end
      S_B: begin
        if (undo_press) begin
          state_d = S_A;
        end else if (enter_press) begin
          load_b  = 1'b1;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (undo_press) begin
          state_d = S_B;
        end else if (enter_press) begin
          load_op = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        load_res = 1'b1;
        state_d  = S_SHOW;
      end
      S_SHOW: begin
        if (undo_press) begin
          clear_err = 1'b1;
          state_d   = S_OP;
        end else if (enter_press) begin
          clear_all = 1'b1;
          state_d   = S_A;
        end
      end
      default: begin
        state_d = S_A;
      end
    endcase

    bus.state_leds = stage_leds(state_q);
    bus.done       = (state_q == S_SHOW);
    if (state_q == S_CALC || state_q == S_SHOW) begin
      bus.disp_value = res_q;
    end else begin
      bus.disp_value = bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      res_q <= '0;
      err_q <= ERR_NONE;
    end else if (clear_all) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      res_q <= '0;
      err_q <= ERR_NONE;
    end else begin
      if (load_a) begin
        a_q <= bus.data_in;
      end
      if (load_b) begin
        b_q <= bus.data_in;
      end
      // Only the two op-code bits are meaningful; upper switches are dropped.
      if (load_op) begin
        op_q <= {{(WIDTH-2){1'b0}}, bus.data_in[1:0]};
      end
      if (load_res) begin
        res_q <= bus.result_in;
        err_q <= bus.error_in;
      end else if (clear_err) begin
        err_q <= ERR_NONE;
      end
    end
  end

  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.OP        = op_q;
  assign bus.error_out = err_q;

endmodule

// File: tb/tb_operand_sequencer.sv
module tb_operand_sequencer;
  localparam int W = 16;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  operand_sequencer_if #(.WIDTH(W)) bus ();

  operand_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: add/sub flag signed overflow with error code 1.
  function automatic logic [W-1:0] alu_res(input logic [W-1:0] a, b, op);
    case (op[1:0])
      2'd0: alu_res = a + b;
      2'd1: alu_res = a - b;
      2'd2: alu_res = a & b;
      default: alu_res = a | b;
    endcase
  endfunction

  function automatic logic [2:0] alu_err(input logic [W-1:0] a, b, op);
    logic [W-1:0] r;
    r = alu_res(a, b, op);
    alu_err = 3'd0;
    if (op[1:0] == 2'd0 && a[W-1] == b[W-1] && r[W-1] != a[W-1]) alu_err = 3'd1;
    if (op[1:0] == 2'd1 && a[W-1] != b[W-1] && r[W-1] != a[W-1]) alu_err = 3'd1;
  endfunction

  assign bus.result_in = alu_res(bus.A, bus.B, bus.OP);
  assign bus.error_in  = alu_err(bus.A, bus.B, bus.OP);

  // Behavioural model. stage: 0=A 1=B 2=OP 3=CALC 4=SHOW.
  // Button presses reach the sequencer one cycle after the level is sampled.
  int           m_stage;
  logic [W-1:0] m_a, m_b, m_op, m_res;
  logic [2:0]   m_err;
  logic         m_prev_e, m_prev_u, m_armed, m_pend_e, m_pend_u;

  always @(posedge clk or posedge reset) begin
    logic e, u;
    if (reset) begin
      m_stage = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_err = '0;
      m_prev_e = 0; m_prev_u = 0; m_armed = 0; m_pend_e = 0; m_pend_u = 0;
    end else begin
      e = m_pend_e;
      u = m_pend_u;
      m_pend_e = m_armed && bus.enter && !m_prev_e;
      m_pend_u = m_armed && bus.undo && !m_prev_u;
      m_prev_e = bus.enter;
      m_prev_u = bus.undo;
      m_armed  = 1'b1;
      if (m_stage == 3) begin
        m_res = alu_res(m_a, m_b, m_op);
        m_err = alu_err(m_a, m_b, m_op);
        m_stage = 4;
      end else if (u) begin
        if (m_stage == 4) begin m_err = '0; m_stage = 2; end
        else if (m_stage > 0) m_stage = m_stage - 1;
      end else if (e) begin
        case (m_stage)
          0: begin m_a = bus.data_in; m_stage = 1; end
          1: begin m_b = bus.data_in; m_stage = 2; end
          2: begin m_op = W'(bus.data_in[1:0]); m_stage = 3; end
          default: begin
            m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_err = '0; m_stage = 0;
          end
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] leds;
    leds = (m_stage == 0) ? 3'b001 : (m_stage == 1) ? 3'b010 :
           (m_stage == 2) ? 3'b100 : 3'b111;
    check("A", bus.A, m_a);
    check("B", bus.B, m_b);
    check("OP", bus.OP, m_op);
    check("disp", bus.disp_value, (m_stage >= 3) ? m_res : bus.data_in);
    check("leds", W'(bus.state_leds), W'(leds));
    check("err", W'(bus.error_out), W'(m_err));
    check("done", W'(bus.done), W'(m_stage == 4));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic press(input logic [W-1:0] v);
    bus.data_in = v;
    bus.enter = 1'b1;
    tick(2);
    bus.enter = 1'b0;
    tick(2);
  endtask

  task automatic undo_press();
    bus.undo = 1'b1;
    tick(2);
    bus.undo = 1'b0;
    tick(2);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.data_in = '0;
    bus.enter = 1'b0;
    bus.undo = 1'b0;
    tick(3);
    check("rst_leds", W'(bus.state_leds), 16'h0001);
    check("rst_A", bus.A, 16'h0000);
    check("rst_done", W'(bus.done), 16'h0000);

    // Enter already high at reset release: no press.
    bus.enter = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(4);
    check("enter_at_release", W'(bus.state_leds), 16'h0001);
    bus.enter = 1'b0;
    tick(2);

    // Basic entry 5 + 3, with latency pinned on the op press.
    press(16'd5);
    press(16'd3);
    bus.data_in = 16'd0;
    bus.enter = 1'b1;
    tick(2);
    check("lat_calc_done", W'(bus.done), 16'h0000);
    check("lat_calc_leds", W'(bus.state_leds), 16'h0007);
    tick(1);
    check("lat_show_done", W'(bus.done), 16'h0001);
    bus.enter = 1'b0;
    tick(2);
    check("sum_A", bus.A, 16'd5);
    check("sum_B", bus.B, 16'd3);
    check("sum_OP", bus.OP, 16'd0);
    check("sum_disp", bus.disp_value, 16'd8);
    check("sum_err", W'(bus.error_out), 16'd0);

    press(16'd0);
    check("clear_A", bus.A, 16'd0);
    check("clear_leds", W'(bus.state_leds), 16'h0001);

    // Overflow latch and clear.
    press(16'h6000);
    press(16'h6000);
    press(16'h0000);
    check("ovf_err", W'(bus.error_out), 16'd1);
    check("ovf_disp", bus.disp_value, 16'hC000);
    press(16'h0000);
    check("ovf_cleared", W'(bus.error_out), 16'd0);
    check("ovf_to_A", W'(bus.state_leds), 16'h0001);

    // Held enter for 50 cycles.
    bus.data_in = 16'd7;
    bus.enter = 1'b1;
    tick(50);
    check("held_leds", W'(bus.state_leds), 16'h0002);
    bus.enter = 1'b0;
    tick(2);
    check("held_A", bus.A, 16'd7);

    // Undo in S_OP, then collision in S_B.
    press(16'd9);
    undo_press();
    check("undo_leds", W'(bus.state_leds), 16'h0002);
    check("undo_A", bus.A, 16'd7);
    bus.enter = 1'b1;
    bus.undo = 1'b1;
    tick(2);
    bus.enter = 1'b0;
    bus.undo = 1'b0;
    tick(2);
    check("collide_leds", W'(bus.state_leds), 16'h0001);
    check("collide_B", bus.B, 16'd9);

    // Op masking, then undo out of S_SHOW.
    press(16'd1);
    press(16'd2);
    press(16'hFFF2);
    check("mask_OP", bus.OP, 16'h0002);
    check("mask_disp", bus.disp_value, 16'h0000);
    undo_press();
    check("undo_show_leds", W'(bus.state_leds), 16'h0004);
    check("undo_show_done", W'(bus.done), 16'h0000);

    // Reset while in S_CALC.
    bus.data_in = 16'd1;
    bus.enter = 1'b1;
    tick(2);
    check("pre_rst_calc", W'(bus.state_leds), 16'h0007);
    bus.data_in = 16'd0;
    bus.enter = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("calc_rst_leds", W'(bus.state_leds), 16'h0001);
    check("calc_rst_A", bus.A, 16'd0);
    check("calc_rst_disp", bus.disp_value, 16'd0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Sequence after reset: 2 - 4.
    press(16'd2);
    press(16'd4);
    press(16'd1);
    check("sub_disp", bus.disp_value, 16'hFFFE);
    check("sub_done", W'(bus.done), 16'd1);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
